// File: rtl/oled_init_sequencer.sv
// SSD1306 power-up sequencer.
// Walks a fixed 18-step table of pin writes, SPI command bytes and millisecond
// waits. It drives the Delay block and the SPI byte sender through two
// request/done handshakes and tells the display controller when it is done.
//
// Handshake semantics (SPI_EN/SPI_FIN and DELAY_EN/DELAY_FIN):
//   The request (xx_EN) is raised in FETCH together with its payload. Request
//   and payload then stay constant until xx_FIN is sampled high. On that edge
//   the request drops. One RELEASE cycle follows with both requests low, so the
//   slave sees EN low and clears FIN before any new request can appear. A FIN
//   that is already high when the request rises is accepted on the first WAIT
//   cycle. There is no timeout.
module oled_init_sequencer #(
    parameter logic [11:0] T_VDD_MS  = 12'd1,
    parameter logic [11:0] T_RES_MS  = 12'd1,
    parameter logic [11:0] T_VBAT_MS = 12'd100
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    output logic        FIN,
    output logic        BUSY,
    output logic        VDD,
    output logic        VBAT,
    output logic        RES,
    output logic        DC,
    output logic [7:0]  SPI_DATA,
    output logic        SPI_EN,
    input  logic        SPI_FIN,
    output logic [11:0] DELAY_MS,
    output logic        DELAY_EN,
    input  logic        DELAY_FIN,
    output logic [2:0]  dbg_state,
    output logic [4:0]  dbg_step
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_WAIT_SPI = 3'd2,
        S_WAIT_DLY = 3'd3,
        S_RELEASE  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        K_PIN = 2'd0,
        K_CMD = 2'd1,
        K_DLY = 2'd2,
        K_END = 2'd3
    } kind_t;

    typedef enum logic [1:0] {
        P_VDD  = 2'd0,
        P_RES  = 2'd1,
        P_VBAT = 2'd2
    } pin_t;

    state_t      state_q, state_d;
    logic [4:0]  step_q, step_d;
    logic        vdd_q, vdd_d;
    logic        vbat_q, vbat_d;
    logic        res_q, res_d;
    logic [7:0]  spi_data_q, spi_data_d;
    logic        spi_en_q, spi_en_d;
    logic [11:0] delay_ms_q, delay_ms_d;
    logic        delay_en_q, delay_en_d;

    kind_t       step_kind;
    pin_t        pin_sel;
    logic        pin_val;
    logic [7:0]  cmd_byte;
    logic [11:0] dly_ms;

    // Step table: decode the current step index into an action.
    always_comb begin
        step_kind = K_END;
        pin_sel   = P_VDD;
        pin_val   = 1'b1;
        cmd_byte  = 8'h00;
        dly_ms    = 12'h000;
        case (step_q)
            5'd0:  begin step_kind = K_PIN; pin_sel = P_VDD;  pin_val = 1'b0; end
            5'd1:  begin step_kind = K_DLY; dly_ms = T_VDD_MS;                end
            5'd2:  begin step_kind = K_CMD; cmd_byte = 8'hAE;                 end
            5'd3:  begin step_kind = K_PIN; pin_sel = P_RES;  pin_val = 1'b0; end
            5'd4:  begin step_kind = K_DLY; dly_ms = T_RES_MS;                end
            5'd5:  begin step_kind = K_PIN; pin_sel = P_RES;  pin_val = 1'b1; end
            5'd6:  begin step_kind = K_DLY; dly_ms = T_RES_MS;                end
            5'd7:  begin step_kind = K_CMD; cmd_byte = 8'h8D;                 end
            5'd8:  begin step_kind = K_CMD; cmd_byte = 8'h14;                 end
            5'd9:  begin step_kind = K_CMD; cmd_byte = 8'hD9;                 end
            5'd10: begin step_kind = K_CMD; cmd_byte = 8'hF1;                 end
            5'd11: begin step_kind = K_PIN; pin_sel = P_VBAT; pin_val = 1'b0; end
            5'd12: begin step_kind = K_DLY; dly_ms = T_VBAT_MS;               end
            5'd13: begin step_kind = K_CMD; cmd_byte = 8'hA1;                 end
            5'd14: begin step_kind = K_CMD; cmd_byte = 8'hC8;                 end
            5'd15: begin step_kind = K_CMD; cmd_byte = 8'hDA;                 end
            5'd16: begin step_kind = K_CMD; cmd_byte = 8'h20;                 end
            5'd17: begin step_kind = K_CMD; cmd_byte = 8'hAF;                 end
            default: step_kind = K_END;
        endcase
    end

    // Next-state and next-output logic; everything holds unless a state acts.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        vdd_d      = vdd_q;
        vbat_d     = vbat_q;
        res_d      = res_q;
        spi_data_d = spi_data_q;
        spi_en_d   = spi_en_q;
        delay_ms_d = delay_ms_q;
        delay_en_d = delay_en_q;
        case (state_q)
            S_IDLE: begin
                if (EN) begin
                    state_d = S_FETCH;
                    step_d  = 5'd0;
                end
            end
            S_FETCH: begin
                case (step_kind)
                    K_PIN: begin
                        case (pin_sel)
                            P_VDD:   vdd_d  = pin_val;
                            P_RES:   res_d  = pin_val;
                            P_VBAT:  vbat_d = pin_val;
                            default: vdd_d  = vdd_q;
                        endcase
                        step_d = step_q + 5'd1;
                    end
                    K_CMD: begin
                        spi_data_d = cmd_byte;
                        spi_en_d   = 1'b1;
                        state_d    = S_WAIT_SPI;
                    end
                    K_DLY: begin
                        delay_ms_d = dly_ms;
                        delay_en_d = 1'b1;
                        state_d    = S_WAIT_DLY;
                    end
                    default: state_d = S_DONE;
                endcase
            end
            S_WAIT_SPI: begin
                if (SPI_FIN) begin
                    spi_en_d = 1'b0;
                    step_d   = step_q + 5'd1;
                    state_d  = S_RELEASE;
                end
            end
            S_WAIT_DLY: begin
                if (DELAY_FIN) begin
                    delay_en_d = 1'b0;
                    step_d     = step_q + 5'd1;
                    state_d    = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_FETCH;
            S_DONE: begin
                if (!EN) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset withdraws requests and drops rails at once.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            step_q     <= 5'd0;
            vdd_q      <= 1'b1;
            vbat_q     <= 1'b1;
            res_q      <= 1'b1;
            spi_data_q <= 8'h00;
            spi_en_q   <= 1'b0;
            delay_ms_q <= 12'h000;
            delay_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            vdd_q      <= vdd_d;
            vbat_q     <= vbat_d;
            res_q      <= res_d;
            spi_data_q <= spi_data_d;
            spi_en_q   <= spi_en_d;
            delay_ms_q <= delay_ms_d;
            delay_en_q <= delay_en_d;
        end
    end

    assign FIN       = (state_q == S_DONE) && EN;
    assign BUSY      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign VDD       = vdd_q;
    assign VBAT      = vbat_q;
    assign RES       = res_q;
    assign DC        = 1'b0;
    assign SPI_DATA  = spi_data_q;
    assign SPI_EN    = spi_en_q;
    assign DELAY_MS  = delay_ms_q;
    assign DELAY_EN  = delay_en_q;
    assign dbg_state = state_q;
    assign dbg_step  = step_q;

endmodule

// File: tb/tb_oled_init_sequencer.sv
// Bench for oled_init_sequencer with stub SPI sender and stub Delay block.
module tb_oled_init_sequencer;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_DLY = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd5;

    // Event kinds seen on the DUT outputs.
    localparam logic [3:0] EV_VDD  = 4'd1;
    localparam logic [3:0] EV_VBAT = 4'd2;
    localparam logic [3:0] EV_RES  = 4'd3;
    localparam logic [3:0] EV_CMD  = 4'd4;
    localparam logic [3:0] EV_DLY  = 4'd5;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic        FIN, BUSY, VDD, VBAT, RES, DC;
    logic [7:0]  SPI_DATA;
    logic        SPI_EN, SPI_FIN;
    logic [11:0] DELAY_MS;
    logic        DELAY_EN, DELAY_FIN;
    logic [2:0]  dbg_state;
    logic [4:0]  dbg_step;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    oled_init_sequencer dut (
        .CLK(CLK), .RST(RST), .EN(EN), .FIN(FIN), .BUSY(BUSY),
        .VDD(VDD), .VBAT(VBAT), .RES(RES), .DC(DC),
        .SPI_DATA(SPI_DATA), .SPI_EN(SPI_EN), .SPI_FIN(SPI_FIN),
        .DELAY_MS(DELAY_MS), .DELAY_EN(DELAY_EN), .DELAY_FIN(DELAY_FIN),
        .dbg_state(dbg_state), .dbg_step(dbg_step)
    );

    // Clock and cycle counter.
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Stub SPI sender: FIN about 4 cycles after EN, held until EN drops.
    logic spi_hold = 1'b0;
    logic spi_fin_r = 1'b0;
    int   spi_cnt = 0;
    always @(posedge CLK) begin
        if (!SPI_EN) begin
            spi_cnt   <= 0;
            spi_fin_r <= 1'b0;
        end else if (spi_cnt == 3) begin
            spi_fin_r <= 1'b1;
        end else begin
            spi_cnt <= spi_cnt + 1;
        end
    end
    assign SPI_FIN = spi_hold | spi_fin_r;

    // Stub Delay block: FIN about DELAY_MS+2 cycles after EN, held until EN drops.
    logic dly_fin_r = 1'b0;
    int   dly_cnt = 0;
    always @(posedge CLK) begin
        if (!DELAY_EN) begin
            dly_cnt   <= 0;
            dly_fin_r <= 1'b0;
        end else if (dly_cnt >= int'(DELAY_MS) + 1) begin
            dly_fin_r <= 1'b1;
        end else begin
            dly_cnt <= dly_cnt + 1;
        end
    end
    assign DELAY_FIN = dly_fin_r;

    // Monitor: record output events and watch handshake rules.
    logic [15:0] obs_q[$];
    int          spi_rise_q[$];
    int          hs_err = 0;
    int          spi_w = 0;
    int          spi_w_max = 0;
    logic        vdd_p, vbat_p, res_p, spi_en_p, dly_en_p, rel_p;
    logic [7:0]  data_p;
    logic [11:0] ms_p;
    always @(negedge CLK) begin
        if (VDD !== vdd_p)   obs_q.push_back({EV_VDD, 11'd0, VDD});
        if (VBAT !== vbat_p) obs_q.push_back({EV_VBAT, 11'd0, VBAT});
        if (RES !== res_p)   obs_q.push_back({EV_RES, 11'd0, RES});
        if (SPI_EN === 1'b1 && spi_en_p !== 1'b1) begin
            obs_q.push_back({EV_CMD, 4'd0, SPI_DATA});
            spi_rise_q.push_back(cyc);
        end
        if (DELAY_EN === 1'b1 && dly_en_p !== 1'b1)
            obs_q.push_back({EV_DLY, DELAY_MS});
        if (SPI_EN === 1'b1 && DELAY_EN === 1'b1) hs_err++;
        if (spi_en_p === 1'b1 && SPI_EN === 1'b1 && SPI_DATA !== data_p) hs_err++;
        if (dly_en_p === 1'b1 && DELAY_EN === 1'b1 && DELAY_MS !== ms_p) hs_err++;
        if (rel_p && (SPI_EN !== 1'b0 || DELAY_EN !== 1'b0)) hs_err++;
        rel_p = (spi_en_p === 1'b1 && SPI_EN === 1'b0) ||
                (dly_en_p === 1'b1 && DELAY_EN === 1'b0);
        if (SPI_EN === 1'b1) begin
            spi_w++;
        end else if (spi_en_p === 1'b1) begin
            if (spi_w > spi_w_max) spi_w_max = spi_w;
            spi_w = 0;
        end
        vdd_p = VDD; vbat_p = VBAT; res_p = RES;
        spi_en_p = SPI_EN; dly_en_p = DELAY_EN;
        data_p = SPI_DATA; ms_p = DELAY_MS;
    end

    // Expected step table: one record per step, with its expected output event.
    typedef struct {
        logic [4:0]  step;
        logic [3:0]  kind;
        logic [11:0] val;
        logic        rerun;   // also produces an event when rails are already on
    } ev_t;
    ev_t         tbl[18];
    logic [15:0] exp_q[$];

    task automatic set_ev(input int i, input logic [3:0] k, input logic [11:0] v,
                          input logic r);
        tbl[i] = '{step: 5'(i), kind: k, val: v, rerun: r};
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // mode 0: DONE; mode 1: BUSY at step stp; mode 2: WAIT_DLY at step stp.
    task automatic wait_for(input int mode, input logic [4:0] stp, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge CLK);
            case (mode)
                0: ok = (dbg_state == ST_DONE);
                1: ok = BUSY && (dbg_step == stp);
                default: ok = (dbg_state == ST_WAIT_DLY) && (dbg_step == stp);
            endcase
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic compare_run(input logic full, input string tag);
        logic [15:0] got;
        exp_q.delete();
        for (int i = 0; i < 18; i++)
            if (full || tbl[i].rerun) exp_q.push_back({tbl[i].kind, tbl[i].val});
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 16'hFFFF;
            check($sformatf("%s_ev%0d", tag, i), {16'd0, got}, {16'd0, exp_q[i]});
        end
    endtask

    initial begin
        set_ev(0,  EV_VDD,  12'd0,   1'b0);
        set_ev(1,  EV_DLY,  12'd1,   1'b1);
        set_ev(2,  EV_CMD,  12'hAE,  1'b1);
        set_ev(3,  EV_RES,  12'd0,   1'b1);
        set_ev(4,  EV_DLY,  12'd1,   1'b1);
        set_ev(5,  EV_RES,  12'd1,   1'b1);
        set_ev(6,  EV_DLY,  12'd1,   1'b1);
        set_ev(7,  EV_CMD,  12'h8D,  1'b1);
        set_ev(8,  EV_CMD,  12'h14,  1'b1);
        set_ev(9,  EV_CMD,  12'hD9,  1'b1);
        set_ev(10, EV_CMD,  12'hF1,  1'b1);
        set_ev(11, EV_VBAT, 12'd0,   1'b0);
        set_ev(12, EV_DLY,  12'd100, 1'b1);
        set_ev(13, EV_CMD,  12'hA1,  1'b1);
        set_ev(14, EV_CMD,  12'hC8,  1'b1);
        set_ev(15, EV_CMD,  12'hDA,  1'b1);
        set_ev(16, EV_CMD,  12'h20,  1'b1);
        set_ev(17, EV_CMD,  12'hAF,  1'b1);

        // Reset values.
        RST = 1'b1;
        EN  = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_vdd",      {31'd0, VDD},      32'd1);
        check("rst_vbat",     {31'd0, VBAT},     32'd1);
        check("rst_res",      {31'd0, RES},      32'd1);
        check("rst_dc",       {31'd0, DC},       32'd0);
        check("rst_spi_en",   {31'd0, SPI_EN},   32'd0);
        check("rst_delay_en", {31'd0, DELAY_EN}, 32'd0);
        check("rst_spi_data", {24'd0, SPI_DATA}, 32'd0);
        check("rst_delay_ms", {20'd0, DELAY_MS}, 32'd0);
        check("rst_fin",      {31'd0, FIN},      32'd0);
        check("rst_busy",     {31'd0, BUSY},     32'd0);
        check("rst_state",    {29'd0, dbg_state}, {29'd0, ST_IDLE});
        check("rst_step",     {27'd0, dbg_step},  32'd0);

        // Full first run: exact ordering of pins, bytes and waits.
        RST = 1'b0;
        @(negedge CLK);
        obs_q.delete();
        EN = 1'b1;
        wait_for(0, 5'd0, "run1_done");
        check("run1_fin",  {31'd0, FIN},  32'd1);
        check("run1_busy", {31'd0, BUSY}, 32'd0);
        compare_run(1'b1, "run1");
        check("run1_handshake", hs_err, 32'd0);

        // Drop EN in DONE: FIN falls combinationally, IDLE next; rerun keeps rails on.
        EN = 1'b0;
        #1;
        check("drop_fin", {31'd0, FIN}, 32'd0);
        @(negedge CLK);
        check("drop_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        obs_q.delete();
        EN = 1'b1;
        wait_for(0, 5'd0, "rerun_done");
        compare_run(1'b0, "rerun");
        check("rerun_vdd",  {31'd0, VDD},  32'd0);
        check("rerun_vbat", {31'd0, VBAT}, 32'd0);

        // EN dropped mid-sequence is ignored; FIN once EN is back in DONE.
        EN = 1'b0;
        @(negedge CLK);
        obs_q.delete();
        EN = 1'b1;
        wait_for(1, 5'd8, "endrop_step8");
        EN = 1'b0;
        wait_for(1, 5'd12, "endrop_step12");
        check("endrop_busy", {31'd0, BUSY}, 32'd1);
        wait_for(1, 5'd15, "endrop_step15");
        EN = 1'b1;
        wait_for(0, 5'd0, "endrop_done");
        check("endrop_fin", {31'd0, FIN}, 32'd1);
        compare_run(1'b0, "endrop");

        // Reset in WAIT_DLY at step 12 aborts; a new EN restarts from step 0.
        EN = 1'b0;
        @(negedge CLK);
        EN = 1'b1;
        wait_for(2, 5'd12, "abort_reach");
        RST = 1'b1;
        EN  = 1'b0;
        @(negedge CLK);
        check("abort_vdd",      {31'd0, VDD},      32'd1);
        check("abort_vbat",     {31'd0, VBAT},     32'd1);
        check("abort_res",      {31'd0, RES},      32'd1);
        check("abort_delay_en", {31'd0, DELAY_EN}, 32'd0);
        check("abort_busy",     {31'd0, BUSY},     32'd0);
        check("abort_state",    {29'd0, dbg_state}, {29'd0, ST_IDLE});
        check("abort_step",     {27'd0, dbg_step},  32'd0);
        RST = 1'b0;
        @(negedge CLK);
        obs_q.delete();
        EN = 1'b1;
        wait_for(0, 5'd0, "restart_done");
        compare_run(1'b1, "restart");

        // SPI FIN already high: each back-to-back byte takes 3 cycles.
        EN = 1'b0;
        @(negedge CLK);
        spi_hold = 1'b1;
        obs_q.delete();
        spi_rise_q.delete();
        spi_w_max = 0;
        EN = 1'b1;
        wait_for(0, 5'd0, "fast_done");
        compare_run(1'b0, "fast");
        check("fast_rises", spi_rise_q.size(), 32'd10);
        check("fast_gap_8d_14", spi_rise_q[2] - spi_rise_q[1], 32'd3);
        check("fast_gap_14_d9", spi_rise_q[3] - spi_rise_q[2], 32'd3);
        check("fast_spi_width", spi_w_max, 32'd1);
        check("all_handshake", hs_err, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
